amoa_frame_seq: RTL and testbench
=================================

# amoa_frame_seq

Frame sequencer for the 8-operand approximate adder tree: accepts a stream of 8×8-bit operand beats, issues each beat to the tree, and accumulates the tree results into a per-frame total. When the tree reports a detected approximation error for a beat, it discards that result and replays the beat as four error-free quarter beats. It sits between an operand source (valid/ready) and a result consumer (valid/ready), and drives the tree's operand inputs directly.

## Interface
- ACC_W, 16, accumulator and out_sum width (≥11)
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- in_valid  in  1  operand beat valid
- in_ready  out  1  beat accepted when in_valid & in_ready
- in_data  in  64  operands; x_i = in_data[8i+7:8i], i = 0..7
- in_last  in  1  beat is the last of its frame
- dp_x  out  64  operand bus to the tree, same packing as in_data
- dp_ed  in  1  tree error-detect; combinational from dp_x, sampled in the issue cycle
- dp_sum  in  11  tree result; valid exactly 2 cycles after issue
- out_valid  out  1  frame result valid
- out_ready  in  1  consumer accepts when out_valid & out_ready
- out_sum  out  ACC_W  frame total, modulo 2^ACC_W
- out_ovf  out  1  accumulator wrapped at least once in this frame
- out_nrep  out  8  beats replayed in this frame, saturates at 255
- out_err  out  1  dp_ed seen during a quarter-beat issue (datapath fault)

## Operation
- States: IDLE, ISSUE, R0, R1, R2, R3, DRAIN, OUT. Reset enters IDLE. IDLE→ISSUE unconditionally on the next cycle.
- ISSUE: in_ready=1, dp_x=in_data on accept, else 0. Accepted beat is stored in beat_r with its last_r flag. If dp_ed=1 on accept, go R0. Else, if in_last, go DRAIN. Otherwise stay in ISSUE.
- R0..R3: in_ready=0. Rk drives dp_x = beat_r with only operands x_{2k} and x_{2k+1} kept and all others zero. R3→DRAIN if last_r, else →ISSUE. Increment out_nrep once on entering R0.
- If dp_ed=1 in any Rk, set out_err sticky. The quarter result is still accumulated.
- Tag pipe: 2-stage shift register of {vld, discard}, loaded each cycle. vld=1 for any accepted beat or Rk issue. discard=dp_ed for ISSUE accepts and 0 for Rk. The stage-2 tag aligns with dp_sum.
- Accumulate: when the stage-2 tag is vld and not discard, acc <= acc + dp_sum, with dp_sum zero-extended to ACC_W+1. A carry out of bit ACC_W-1 sets out_ovf sticky.
- DRAIN: in_ready=0. Wait until both tag stages are empty and the last accumulation has completed, then go OUT.
- OUT: out_valid=1, and out_sum/out_ovf/out_nrep/out_err are held stable. On out_ready, clear acc, ovf, nrep and err, and go ISSUE.
- A new frame never starts before the previous result is accepted.
- Only the data path depends on dp_ed: in_ready, out_valid and dp_x depend on state and in_data only, never on out_ready in the same cycle.
- Frames of one beat, and back-to-back replayed beats, are legal.

## Timing
- Reset values: in_ready=0, out_valid=0, dp_x=0, out_sum=0, out_ovf=0, out_nrep=0, out_err=0, tag pipe empty, state IDLE.
- in_ready first rises in the second cycle after rst deasserts.
- Reset asserted in any state, including mid-replay or DRAIN, aborts the frame on that edge. Partial accumulation and in-flight tags are dropped, and no out_valid is produced.
- Issue in cycle t → dp_sum sampled in cycle t+2 → acc updated at the end of t+2.
- Last issue in cycle t → out_valid rises in cycle t+3. The last issue is the last-beat accept, or R3 if that beat was replayed.
- A replayed beat costs 4 extra issue cycles; in_ready is low for exactly 4 cycles after the erroring accept.
- No-error throughput is 1 beat/cycle within a frame. The frame overhead is 3 DRAIN/OUT cycles plus the out_ready wait.

## Test plan
- Bench datapath model: dp_sum = exact operand sum 2 cycles later. dp_ed is forced per beat by the test; when forced, the model returns exact−4.
- Reset:
  - Stimulus: hold rst 3 cycles with in_valid=1, then release.
  - Required: all outputs 0 during reset, in_ready=1 from the second cycle after release.
- Clean frame:
  - Stimulus: 3 beats, all operands 0x10 (each beat sums to 128), dp_ed=0, out_ready=1.
  - Required: out_sum=384, out_nrep=0, out_ovf=0, out_err=0; out_valid exactly 3 cycles after the last accept.
- Replay:
  - Stimulus: single-beat frame x_i=i+1, dp_ed forced on the accept (model returns 32).
  - Required: dp_x quarters sum to 3, 7, 11, 15; in_ready low for 4 cycles; out_sum=36, out_nrep=1, out_err=0. Forcing dp_ed during R1 additionally gives out_err=1.
- Overflow:
  - Stimulus: 300-beat frame of all 0xFF (each beat sums to 2040), ACC_W=16.
  - Required: out_ovf=1, out_sum=22176.
- Backpressure:
  - Stimulus: out_ready low for 5 cycles after out_valid rises.
  - Required: out_valid and out_sum held constant, in_ready=0 throughout; after the accept, a new frame's beat is accepted in the next cycle with acc cleared.
- Reset mid-replay:
  - Stimulus: assert rst in R2 of a replayed beat, then send a clean 1-beat frame of all 0x01.
  - Required: no stale out_valid; next out_sum=8, out_nrep=0.

Source files
------------

// File: rtl/amoa_frame_seq.sv
// amoa_frame_seq
//   Frame sequencer for the 8-operand approximate adder tree. Accepts 8x8-bit
//   operand beats, issues each beat to the tree and accumulates the tree
//   results into a per-frame total. A beat whose issue raised the tree's
//   error-detect is discarded and replayed as four error-free quarter beats
//   (two operands each).
//
// Ports
//   clk, rst         clock; synchronous active-high reset
//   in_valid/ready   operand beat handshake; in_data packs x_i at [8i+7:8i]
//   in_last          beat closes its frame
//   dp_x             operand bus to the tree (same packing as in_data)
//   dp_ed            tree error-detect, combinational from dp_x
//   dp_sum           tree result, valid two cycles after issue
//   out_valid/ready  frame result handshake
//   out_sum          frame total modulo 2^ACC_W
//   out_ovf          accumulator wrapped at least once in the frame
//   out_nrep         replayed beats in the frame, saturating at 255
//   out_err          error-detect seen during a quarter-beat issue
module amoa_frame_seq #(
  parameter int unsigned ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_data,
  input  logic             in_last,
  output logic [63:0]      dp_x,
  input  logic             dp_ed,
  input  logic [10:0]      dp_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  output logic [7:0]       out_nrep,
  output logic             out_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_R0,
    S_R1,
    S_R2,
    S_R3,
    S_DRAIN,
    S_OUT
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [63:0]      r_beat;
  logic             r_last;

  // Tag pipe: stage 2 lines up with dp_sum of the issue two cycles earlier.
  logic             r_tag1_vld;
  logic             r_tag1_dis;
  logic             r_tag2_vld;
  logic             r_tag2_dis;

  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;
  logic [7:0]       r_nrep;
  logic             r_err;

  logic             w_in_ready;
  logic             w_out_valid;
  logic [63:0]      w_dp_x;
  logic             w_accept;
  logic             w_quarter;
  logic             w_enter_rep;
  logic             w_acc_en;
  logic [ACC_W:0]   w_acc_sum;

  // Next state, handshake and operand bus. dp_ed only steers the next state;
  // the outputs of this block never depend on it.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_dp_x      = '0;
    w_accept    = 1'b0;
    w_quarter   = 1'b0;
    w_enter_rep = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        w_in_ready = 1'b1;
        if (in_valid) begin
          w_accept = 1'b1;
          w_dp_x   = in_data;
          if (dp_ed) begin
            w_state_nxt = S_R0;
            w_enter_rep = 1'b1;
          end else if (in_last) begin
            w_state_nxt = S_DRAIN;
          end
        end
      end
      S_R0: begin
        w_quarter   = 1'b1;
        w_dp_x      = r_beat & 64'h0000_0000_0000_FFFF;
        w_state_nxt = S_R1;
      end
      S_R1: begin
        w_quarter   = 1'b1;
        w_dp_x      = r_beat & 64'h0000_0000_FFFF_0000;
        w_state_nxt = S_R2;
      end
      S_R2: begin
        w_quarter   = 1'b1;
        w_dp_x      = r_beat & 64'h0000_FFFF_0000_0000;
        w_state_nxt = S_R3;
      end
      S_R3: begin
        w_quarter   = 1'b1;
        w_dp_x      = r_beat & 64'hFFFF_0000_0000_0000;
        w_state_nxt = r_last ? S_DRAIN : S_ISSUE;
      end
      S_DRAIN: begin
        // Nothing is issued here, so once stage 1 is empty the final result
        // sits in stage 2 and is added on this edge; OUT then shows the total.
        if (!r_tag1_vld) begin
          w_state_nxt = S_OUT;
        end
      end
      S_OUT: begin
        w_out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = S_ISSUE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_acc_en  = r_tag2_vld & ~r_tag2_dis;
  assign w_acc_sum = {1'b0, r_acc} + {{(ACC_W - 10){1'b0}}, dp_sum};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_beat     <= '0;
      r_last     <= 1'b0;
      r_tag1_vld <= 1'b0;
      r_tag1_dis <= 1'b0;
      r_tag2_vld <= 1'b0;
      r_tag2_dis <= 1'b0;
      r_acc      <= '0;
      r_ovf      <= 1'b0;
      r_nrep     <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if (w_accept) begin
        r_beat <= in_data;
        r_last <= in_last;
      end

      r_tag1_vld <= w_accept | w_quarter;
      r_tag1_dis <= w_accept & dp_ed;
      r_tag2_vld <= r_tag1_vld;
      r_tag2_dis <= r_tag1_dis;

      if (w_quarter && dp_ed) begin
        r_err <= 1'b1;
      end

      if (w_enter_rep && (r_nrep != 8'hFF)) begin
        r_nrep <= r_nrep + 8'd1;
      end

      if (w_acc_en) begin
        r_acc <= w_acc_sum[ACC_W-1:0];
        if (w_acc_sum[ACC_W]) begin
          r_ovf <= 1'b1;
        end
      end

      // The tag pipe is empty in OUT, so this clear never races an add.
      if ((r_state == S_OUT) && out_ready) begin
        r_acc  <= '0;
        r_ovf  <= 1'b0;
        r_nrep <= '0;
        r_err  <= 1'b0;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign dp_x      = w_dp_x;
  assign out_sum   = r_acc;
  assign out_ovf   = r_ovf;
  assign out_nrep  = r_nrep;
  assign out_err   = r_err;

endmodule

// File: tb/tb_amoa_frame_seq.sv
// tb_amoa_frame_seq
//   Self-checking bench for amoa_frame_seq with a behavioural adder-tree model
//   (exact operand sum, two-cycle latency, exact-4 when error-detect is forced)
//   and a frame-result scoreboard.
module tb_amoa_frame_seq;

  localparam int unsigned ACC_W = 16;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [63:0]      in_data;
  logic             in_last;
  logic [63:0]      dp_x;
  logic             dp_ed;
  logic [10:0]      dp_sum;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;
  logic [7:0]       out_nrep;
  logic             out_err;

  amoa_frame_seq #(.ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .dp_x      (dp_x),
    .dp_ed     (dp_ed),
    .dp_sum    (dp_sum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .out_nrep  (out_nrep),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int bytesum(input logic [63:0] v);
    int s;
    s = 0;
    for (int i = 0; i < 8; i++) s += int'(v[8*i +: 8]);
    return s;
  endfunction

  // ---------------- adder-tree model and error-detect forcing ----------------
  logic       beat_ed;
  logic [3:0] rmask;
  logic [3:0] q_mask;
  int         q_idx = -1;
  logic [10:0] s1 = '0;
  logic [10:0] s2 = '0;

  assign dp_ed  = (in_valid && in_ready && beat_ed) ||
                  ((q_idx >= 0) && q_mask[q_idx[1:0]]);
  assign dp_sum = s2;

  always @(posedge clk) begin
    s1 <= 11'(bytesum(dp_x) - (dp_ed ? 4 : 0));
    s2 <= s1;
  end

  // Quarter-beat position follows the four cycles after an erroring accept.
  always @(posedge clk) begin
    if (rst) q_idx <= -1;
    else if (q_idx >= 0) q_idx <= (q_idx == 3) ? -1 : q_idx + 1;
    else if (in_valid && in_ready && beat_ed) begin
      q_idx  <= 0;
      q_mask <= rmask;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [15:0] sum;
    logic        ovf;
    logic [7:0]  nrep;
    logic        err;
  } res_t;

  res_t sb[$];
  int   f_sum  = 0;
  int   f_nrep = 0;
  bit   f_err  = 0;

  always @(negedge clk) begin
    res_t e;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) check("out_unexpected", 64'(out_valid), 64'd0);
      else begin
        e = sb.pop_front();
        check("out_sum",  64'(out_sum),  64'(e.sum));
        check("out_ovf",  64'(out_ovf),  64'(e.ovf));
        check("out_nrep", 64'(out_nrep), 64'(e.nrep));
        check("out_err",  64'(out_err),  64'(e.err));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [63:0] d, input bit last, input bit ed,
                           input logic [3:0] rm, input bit expect_out);
    int   budget;
    res_t r;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    beat_ed  = ed;
    rmask    = rm;
    budget   = 0;
    while (!in_ready && budget < 50) begin
      step();
      budget++;
    end
    if (!in_ready) begin
      check("accept_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
      return;
    end
    step();
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    beat_ed  = 1'b0;
    if (ed) begin
      f_nrep++;
      f_sum += bytesum(d) - 4 * $countones(rm);
      if (rm != 0) f_err = 1;
    end else begin
      f_sum += bytesum(d);
    end
    if (last) begin
      if (expect_out) begin
        r.sum  = 16'(f_sum % 65536);
        r.ovf  = (f_sum >= 65536);
        r.nrep = (f_nrep > 255) ? 8'd255 : 8'(f_nrep);
        r.err  = f_err;
        sb.push_back(r);
      end
      f_sum  = 0;
      f_nrep = 0;
      f_err  = 0;
    end
  endtask

  // Called in the cycle after the last issue; out_valid must rise two cycles later.
  task automatic check_latency(input string tag);
    check(tag, 64'(out_valid), 64'd0);
    step();
    check(tag, 64'(out_valid), 64'd0);
    step();
    check(tag, 64'(out_valid), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  logic [63:0] d_inc;
  logic [63:0] d01;
  logic [63:0] d02;
  logic [63:0] d05;
  logic [63:0] d10;
  logic [63:0] dff;

  initial begin
    for (int i = 0; i < 8; i++) d_inc[8*i +: 8] = 8'(i + 1);
    d01 = 64'h0101_0101_0101_0101;
    d02 = 64'h0202_0202_0202_0202;
    d05 = 64'h0505_0505_0505_0505;
    d10 = 64'h1010_1010_1010_1010;
    dff = 64'hFFFF_FFFF_FFFF_FFFF;

    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = d10;
    in_last   = 1'b0;
    beat_ed   = 1'b0;
    rmask     = '0;
    out_ready = 1'b1;

    // Reset held three cycles with a valid beat pending
    for (int c = 0; c < 3; c++) begin
      step();
      check("rst_in_ready",  64'(in_ready),  64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_dp_x",      dp_x,           64'd0);
      check("rst_out_sum",   64'(out_sum),   64'd0);
      check("rst_out_ovf",   64'(out_ovf),   64'd0);
      check("rst_out_nrep",  64'(out_nrep),  64'd0);
      check("rst_out_err",   64'(out_err),   64'd0);
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    check("post_rst_ready_c1", 64'(in_ready), 64'd0);
    step();
    check("post_rst_ready_c2", 64'(in_ready), 64'd1);

    // Clean 3-beat frame: 3 x 128
    send_beat(d10, 1'b0, 1'b0, 4'b0000, 1'b1);
    send_beat(d10, 1'b0, 1'b0, 4'b0000, 1'b1);
    send_beat(d10, 1'b1, 1'b0, 4'b0000, 1'b1);
    check_latency("clean_latency");
    step();

    // Replayed single-beat frame, quarters sum to 3, 7, 11, 15
    send_beat(d_inc, 1'b1, 1'b1, 4'b0000, 1'b1);
    check("rep_q0", dp_x, d_inc & 64'h0000_0000_0000_FFFF);
    check("rep_q0_ready", 64'(in_ready), 64'd0);
    step();
    check("rep_q1", dp_x, d_inc & 64'h0000_0000_FFFF_0000);
    step();
    check("rep_q2", dp_x, d_inc & 64'h0000_FFFF_0000_0000);
    step();
    check("rep_q3", dp_x, d_inc & 64'hFFFF_0000_0000_0000);
    check("rep_q3_sum", 64'(bytesum(dp_x)), 64'd15);
    step();
    check_latency("rep_latency");
    step();

    // Replay with an error on quarter 1, followed by a clean last beat
    send_beat(d_inc, 1'b0, 1'b1, 4'b0010, 1'b1);
    for (int c = 0; c < 4; c++) begin
      check("rep_ready_low", 64'(in_ready), 64'd0);
      step();
    end
    check("rep_ready_back", 64'(in_ready), 64'd1);
    send_beat(d01, 1'b1, 1'b0, 4'b0000, 1'b1);
    check_latency("rep2_latency");
    step();

    // Overflow: 300 beats of 0xFF
    for (int b = 0; b < 300; b++) send_beat(dff, (b == 299), 1'b0, 4'b0000, 1'b1);
    check_latency("ovf_latency");
    step();

    // Backpressure on the result
    out_ready = 1'b0;
    send_beat(d05, 1'b1, 1'b0, 4'b0000, 1'b1);
    for (int c = 0; c < 10 && !out_valid; c++) step();
    check("bp_valid_rise", 64'(out_valid), 64'd1);
    in_valid = 1'b1;
    in_data  = d02;
    in_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check("bp_valid_hold", 64'(out_valid), 64'd1);
      check("bp_sum_hold",   64'(out_sum),   64'd40);
      check("bp_ready_low",  64'(in_ready),  64'd0);
      check("bp_dp_x_zero",  dp_x,           64'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    check("bp_next_ready", 64'(in_ready), 64'd1);
    check("bp_acc_clear",  64'(out_sum),  64'd0);
    send_beat(d02, 1'b1, 1'b0, 4'b0000, 1'b1);
    check_latency("bp_next_latency");
    step();

    // Reset during R2 of a replayed beat
    send_beat(d_inc, 1'b1, 1'b1, 4'b0000, 1'b0);
    step();
    step();
    check("mid_rep_q2", dp_x, d_inc & 64'h0000_FFFF_0000_0000);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_ready", 64'(in_ready),  64'd0);
    check("mid_rst_sum",   64'(out_sum),   64'd0);
    check("mid_rst_nrep",  64'(out_nrep),  64'd0);
    for (int c = 0; c < 4; c++) begin
      step();
      check("mid_rst_no_valid", 64'(out_valid), 64'd0);
    end
    send_beat(d01, 1'b1, 1'b0, 4'b0000, 1'b1);
    check_latency("mid_rst_latency");

    for (int c = 0; c < 4; c++) step();
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
